// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle datapath: FSM states, opcodes, ALU op and
// operand-select codes, and the control-word bundle. Used by the controller and ALU decoder.
package multi_cycle_control_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ENC_W    = 4;

  typedef enum logic [ENC_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand: register, constant 4, sign-extended imm, shifted imm
  localparam logic [1:0] ALUB_REG  = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;
  localparam logic [1:0] ALUB_SHL  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] aluop;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style main controller: one FSM, registered state, combinational controls.
// Optional ADDI support is enabled with `define MULTI_CYCLE_CONTROL_ADDI_EN.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [1:0]         aluop,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] ST_FETCH  = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] ST_DECODE = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] ST_MEMADR = STATE_W'(S_MEMADR);
  localparam logic [STATE_W-1:0] ST_MEMRD  = STATE_W'(S_MEMRD);
  localparam logic [STATE_W-1:0] ST_MEMWB  = STATE_W'(S_MEMWB);
  localparam logic [STATE_W-1:0] ST_MEMWR  = STATE_W'(S_MEMWR);
  localparam logic [STATE_W-1:0] ST_EXEC   = STATE_W'(S_EXEC);
  localparam logic [STATE_W-1:0] ST_ALUWB  = STATE_W'(S_ALUWB);
  localparam logic [STATE_W-1:0] ST_BEQ    = STATE_W'(S_BEQ);
  localparam logic [STATE_W-1:0] ST_JUMP   = STATE_W'(S_JUMP);
`ifdef MULTI_CYCLE_CONTROL_ADDI_EN
  localparam logic [STATE_W-1:0] ST_ADDIEX = STATE_W'(S_ADDIEX);
  localparam logic [STATE_W-1:0] ST_ADDIWB = STATE_W'(S_ADDIWB);
`endif

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctrl_t              ctrl;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next state and control word; anything not set for a state stays 0
  always_comb begin
    ctrl    = '0;
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        state_d        = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = ALUB_SHL;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BEQ;
`ifdef MULTI_CYCLE_CONTROL_ADDI_EN
          OP_ADDI:      state_d = ST_ADDIEX;
`endif
          OP_J:         state_d = ST_JUMP;
          default:      ctrl.illegal = 1'b1;
        endcase
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        if (opcode == OP_LW)      state_d = ST_MEMRD;
        else if (opcode == OP_SW) state_d = ST_MEMWR;
      end
      ST_MEMRD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
        state_d       = mem_ready ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.i_or_d     = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
        state_d         = mem_ready ? ST_FETCH : ST_MEMWR;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.aluop     = ALUOP_FUNCT;
        state_d        = ST_ALUWB;
      end
      ST_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.aluop         = ALUOP_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
        ctrl.instr_done    = 1'b1;
      end
`ifdef MULTI_CYCLE_CONTROL_ADDI_EN
      ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        state_d        = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`endif
      ST_JUMP: begin
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset silences every strobe in the same cycle, not just after the edge
    if (rst) ctrl = '0;
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign pc_source     = ctrl.pc_source;
  assign aluop         = ctrl.aluop;
  assign instr_done    = ctrl.instr_done;
  assign illegal       = ctrl.illegal;
  assign state         = rst ? '0 : state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed instruction walks plus randomized
// traffic compared every cycle against an instruction-route model.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, pc_source, aluop;
  logic [3:0] state;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  multi_cycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .aluop(aluop), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Model: each instruction is a fixed route of step numbers chosen at decode
  int ms = 0;
  int plan[$];

  function automatic bit legal_op(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010: return 1'b1;
`ifdef MULTI_CYCLE_CONTROL_ADDI_EN
      6'b001000: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pop_next();
    if (plan.size() > 0) return plan.pop_front();
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ms = 0;
      plan.delete();
    end else begin
      case (ms)
        0: if (mem_ready) ms = 1;
        1: begin
          plan.delete();
          case (opcode)
            6'b100011: plan = {2, 3, 4};
            6'b101011: plan = {2, 5};
            6'b000000: plan = {6, 7};
            6'b000100: plan = {8};
            6'b000010: plan = {11};
`ifdef MULTI_CYCLE_CONTROL_ADDI_EN
            6'b001000: plan = {9, 10};
`endif
            default: ;
          endcase
          ms = pop_next();
        end
        3, 5: if (mem_ready) ms = pop_next();
        default: ms = pop_next();
      endcase
    end
  end

  // Control vector order: pw pwc iod mrd mwr irw m2r rw rd asa asb[2] pcs[2] aop[2] done ill
  function automatic logic [17:0] exp_ctrl(input int s, input bit r, input bit mr,
                                           input logic [5:0] op);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa, done, ill;
    logic [1:0] asb, pcs, aop;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa, done, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    if (!r) begin
      case (s)
        0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
        1:  begin asb = 2'b11; ill = !legal_op(op); end
        2:  begin asa = 1; asb = 2'b10; end
        3:  begin iod = 1; mrd = 1; end
        4:  begin m2r = 1; rw = 1; done = 1; end
        5:  begin iod = 1; mwr = 1; done = mr; end
        6:  begin asa = 1; aop = 2'b10; end
        7:  begin rd = 1; rw = 1; done = 1; end
        8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pwc = 1; done = 1; end
        9:  begin asa = 1; asb = 2'b10; end
        10: begin rw = 1; done = 1; end
        11: begin pcs = 2'b10; pw = 1; done = 1; end
        default: ;
      endcase
    end
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa, asb, pcs, aop, done, ill};
  endfunction

  wire [17:0] dut_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                          mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source,
                          aluop, instr_done, illegal};

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      logic [17:0] e;
      logic [3:0]  es;
      e  = exp_ctrl(ms, rst, mem_ready, opcode);
      es = rst ? 4'd0 : 4'(ms);
      n_chk++;
      if (dut_ctrl !== e) begin
        n_fail++;
        $display("FAIL model_ctrl t=%0t: got %b expected %b (step %0d)", $time, dut_ctrl, e, ms);
      end
      n_chk++;
      if (state !== es) begin
        n_fail++;
        $display("FAIL model_state t=%0t: got %0d expected %0d", $time, state, es);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge, return mid-cycle for checks
  task automatic cyc(input bit r, input logic [5:0] op, input bit mr);
    @(posedge clk);
    #1;
    rst = r; opcode = op; mem_ready = mr;
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 6'd0, 0);
    chk_en = 1'b1;
    cyc(1, 6'd0, 1);
    chk("reset_state", 32'(state), 0);
    chk("reset_strobes", 32'({mem_read, mem_write, reg_write, pc_write, ir_write}), 0);

    // RTYPE: 0,1,6,7 with garbage opcode outside decode
    cyc(0, 6'h00, 1); chk("rt_fetch", 32'(state), 0); chk("rt_irw", 32'(ir_write), 1);
    cyc(0, 6'h00, 1); chk("rt_decode", 32'(state), 1);
    cyc(0, 6'h3f, 1); chk("rt_exec", 32'(state), 6); chk("rt_aluop", 32'(aluop), 2);
    chk("rt_exec_rw", 32'({reg_write, reg_dst, instr_done}), 0);
    cyc(0, 6'h15, 1); chk("rt_aluwb", 32'(state), 7);
    chk("rt_wb_strobes", 32'({reg_write, reg_dst, instr_done}), 3'b111);
    cyc(0, 6'h00, 1); chk("rt_back", 32'(state), 0);

    // LW with three wait cycles in MEMRD
    cyc(0, 6'h23, 1); chk("lw_decode", 32'(state), 1);
    cyc(0, 6'h23, 1); chk("lw_memadr", 32'(state), 2);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 6'h3f, (i == 3)); chk("lw_memrd", 32'(state), 3); chk("lw_iord", 32'(i_or_d), 1);
    end
    cyc(0, 6'h00, 0); chk("lw_memwb", 32'(state), 4); chk("lw_m2r", 32'(mem_to_reg), 1);
    cyc(0, 6'h00, 0); chk("lw_stall_fetch", 32'(ir_write), 0);
    cyc(0, 6'h00, 1); chk("lw_fetch", 32'(state), 0);

    // BEQ
    cyc(0, 6'h04, 1); chk("beq_decode", 32'(state), 1);
    cyc(0, 6'h00, 1); chk("beq_state", 32'(state), 8);
    chk("beq_ctrl", 32'({aluop, pc_write_cond, pc_source}), 5'b01_1_01);
    cyc(0, 6'h00, 1); chk("beq_back", 32'(state), 0);

    // Illegal opcode
    cyc(0, 6'h3f, 1); chk("ill_pulse", 32'(illegal), 1);
    chk("ill_strobes", 32'({mem_write, reg_write, pc_write, pc_write_cond}), 0);
    cyc(0, 6'h00, 0); chk("ill_state", 32'(state), 0); chk("ill_clear", 32'(illegal), 0);
    cyc(0, 6'h00, 1);

    // ADDI
    cyc(0, 6'h08, 1);
`ifdef MULTI_CYCLE_CONTROL_ADDI_EN
    chk("addi_legal", 32'(illegal), 0);
    cyc(0, 6'h00, 1); chk("addi_ex", 32'(state), 9);
    cyc(0, 6'h00, 1); chk("addi_wb", 32'(state), 10); chk("addi_rw", 32'(reg_write), 1);
    cyc(0, 6'h00, 1); chk("addi_back", 32'(state), 0);
`else
    chk("addi_illegal", 32'(illegal), 1);
    cyc(0, 6'h00, 1); chk("addi_back", 32'(state), 0);
`endif

    // J
    cyc(0, 6'h02, 1); chk("j_decode", 32'(state), 1);
    cyc(0, 6'h00, 1); chk("j_state", 32'(state), 11);
    chk("j_ctrl", 32'({pc_write, pc_source, instr_done}), 4'b1_10_1);
    cyc(0, 6'h00, 1); chk("j_back", 32'(state), 0);

    // SW with one wait cycle
    cyc(0, 6'h2b, 1);
    cyc(0, 6'h2b, 1); chk("sw_memadr", 32'(state), 2);
    cyc(0, 6'h00, 0); chk("sw_memwr", 32'(state), 5); chk("sw_wait_done", 32'(instr_done), 0);
    cyc(0, 6'h00, 1); chk("sw_done", 32'({mem_write, instr_done}), 2'b11);
    cyc(0, 6'h00, 1); chk("sw_back", 32'(state), 0);

    // Reset while waiting in MEMRD
    cyc(0, 6'h23, 1);
    cyc(0, 6'h23, 1);
    cyc(0, 6'h00, 0); chk("rst_in_memrd", 32'(state), 3);
    cyc(1, 6'h00, 0); chk("rst_gate", 32'({state, mem_read}), 0);
    cyc(1, 6'h00, 0); chk("rst_hold", 32'({state, mem_read}), 0);
    cyc(0, 6'h00, 1); chk("rst_fetch", 32'(state), 0); chk("rst_fetch_mrd", 32'(mem_read), 1);

    // Random traffic; opcode only held steady where the controller samples it
    begin
      logic [5:0] cur_op;
      logic [5:0] ops [6];
      ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02};
      cur_op = 6'h00;
      for (int n = 0; n < 3000; n++) begin
        @(posedge clk);
        #1;
        if (ms == 0) begin
          int k;
          k = int'($urandom_range(0, 6));
          cur_op = (k == 6) ? 6'($urandom) : ops[k];
        end
        rst       = ($urandom_range(0, 63) == 0);
        mem_ready = ($urandom_range(0, 9) < 7);
        opcode    = (ms == 1 || ms == 2) ? cur_op : 6'($urandom);
      end
    end
    @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter STATE_W, default 4, width of the state register.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  6  instruction-register opcode field.
REQ-005 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-006 SHALL have outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, each 1 bit.
REQ-007 SHALL have outputs alu_src_b[1:0], pc_source[1:0], aluop[1:0]; aluop drives the ALU control decoder (00 add, 01 sub, 10 funct-decoded).
REQ-008 SHALL have outputs instr_done (1, one-cycle pulse), illegal (1, one-cycle pulse), state[STATE_W-1:0] (debug).

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-010 SHALL decode opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
REQ-011 SHALL drive every output not listed for a state to 0.
REQ-012 FETCH: mem_read=1, alu_src_b=01; ir_write=pc_write=mem_ready; stay while mem_ready=0, else -> DECODE.
REQ-013 DECODE: alu_src_b=11; next: LW/SW -> MEMADR, RTYPE -> EXEC, BEQ -> BEQ, ADDI -> ADDIEX, J -> JUMP, else illegal=1 and -> FETCH.
REQ-014 MEMADR: alu_src_a=1, alu_src_b=10; LW -> MEMRD, SW -> MEMWR.
REQ-015 MEMRD: i_or_d=1, mem_read=1; hold until mem_ready=1, then -> MEMWB.
REQ-016 MEMWB: mem_to_reg=1, reg_write=1, instr_done=1; -> FETCH.
REQ-017 MEMWR: i_or_d=1, mem_write=1; hold until mem_ready=1, then instr_done=1 and -> FETCH.
REQ-018 EXEC: alu_src_a=1, aluop=10; -> ALUWB. ALUWB: reg_dst=1, reg_write=1, instr_done=1; -> FETCH.
REQ-019 BEQ: alu_src_a=1, aluop=01, pc_source=01, pc_write_cond=1, instr_done=1; -> FETCH.
REQ-020 ADDIEX: alu_src_a=1, alu_src_b=10; -> ADDIWB. ADDIWB: reg_write=1, instr_done=1; -> FETCH.
REQ-021 JUMP: pc_source=10, pc_write=1, instr_done=1; -> FETCH.
REQ-022 Latency with mem_ready=1 throughout: J/BEQ 3 cycles, RTYPE/ADDI/SW 4, LW 5.
REQ-023 opcode SHALL be sampled only in DECODE and MEMADR; changes elsewhere have no effect.
REQ-024 Unreachable state encodings SHALL transition to FETCH next cycle with all outputs 0.

Reset
REQ-025 rst=1 at a clock edge SHALL force state=FETCH regardless of current state, including mid-wait in MEMRD/MEMWR.
REQ-026 While rst=1, all outputs SHALL be 0 except state=0; no write strobe asserts during reset.

Configuration
REQ-027 Macro MULTI_CYCLE_CONTROL_ADDI_EN defined: ADDI handled per REQ-020.
REQ-028 Macro undefined: states ADDIEX/ADDIWB absent; opcode 001000 treated as illegal per REQ-013.

Structure
REQ-029 State encodings, opcode constants and aluop encodings SHALL live in a shared include beside the ALU definitions, used by this block and the ALU control decoder.
REQ-030 No sub-module; single FSM with registered state, combinational next-state and output logic.

Verification
REQ-031 rst high 2 cycles mid-MEMRD -> state=0, mem_read=0 on the cycle after, then FETCH behaviour.
REQ-032 RTYPE, mem_ready=1 -> states 0,1,6,7; aluop=10 in EXEC; reg_write=1, reg_dst=1 and instr_done=1 only in ALUWB.
REQ-033 LW with mem_ready low 3 cycles in MEMRD -> state 3 held 4 cycles, i_or_d=1, then MEMWB with mem_to_reg=1.
REQ-034 BEQ -> state 8 with aluop=01, pc_write_cond=1, pc_source=01; back to FETCH next cycle.
REQ-035 opcode 111111 in DECODE -> illegal pulse 1 cycle, no write strobes, state 0 next.
REQ-036 opcode 001000 -> with macro: states 9,10 and reg_write=1; without: illegal pulse.
